control_unit: RTL
=================

# control_unit

Sequencing FSM for the 8-bit accumulator CPU datapath: the 4-bit PC/AR, 8-bit IR/DR/AC, the 16×8 synchronous memory and the 8-bit ALU. It runs fetch, decode, indirect-address resolution, operand read and execute by generating every load, increment, select, write and enable strobe. It also publishes the instruction-cycle counter SC and latched decode fields. It replaces ad-hoc SC logic inside the CPU top level.

## Interface
Parameters: none. Instruction format fixed: bit7 = I (indirect), bits6:4 = opcode, bits3:0 = address.

Ports (clock and reset first):
- CLK  in  1  single clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  sampled in IDLE/HALT; begins instruction execution.
- dr_in  in  8  memory data output (DR), valid one cycle after AR load.
- ar_ld  out  1  load AR from source given by ar_sel.
- ar_sel  out  2  AR source: 00 PC, 01 IR[3:0], 10 DR[3:0], 11 unused.
- pc_inc  out  1  PC <= PC+1, 4-bit wrap.
- ir_ld  out  1  datapath IR <= DR.
- mem_write  out  1  M[AR] <= AC at the edge ending the cycle.
- alu_en  out  1  ALU evaluate strobe.
- alu_op  out  3  ALU opcode, equal to the latched opcode.
- ac_ld  out  1  AC load.
- ac_src  out  1  AC source: 0 ALU result, 1 DR.
- SC  out  3  cycle index within the current instruction.
- opcode  out  3  latched IR[6:4].
- I  out  1  latched IR[7].
- busy  out  1  high in any fetch, decode or execute state.
- done  out  1  one-cycle pulse in EXE; instruction retires.
- halted  out  1  high in HALT.

## Operation
- Instruction set:
  - Memory-reference: 000 ADD, 001 SUB, 010 XOR, 100 LDA, 101 STA.
  - Register-reference (I and address ignored): 011 SHL (AC+AC), 110 CMA (~AC), 111 HLT.
- States: IDLE, F0, F1, F2, DEC, IND0, IND1, RD, EXE, HALT.
- All outputs are Moore, decoded only from state and the internal IR latch.
- IDLE: all strobes 0. If start=1, go to F0.
- F0: ar_ld=1, ar_sel=00. Go to F1.
- F1: pc_inc=1. Memory captures M[AR] into DR. Go to F2.
- F2: ir_ld=1. Internal IR <= dr_in. Go to DEC.
- DEC:
  - Register-reference opcode: go to EXE.
  - Otherwise ar_ld=1, ar_sel=01.
  - If I=1, go to IND0.
  - Else if STA, go to EXE.
  - Else go to RD.
- IND0: memory read cycle, no strobes. Go to IND1.
- IND1: ar_ld=1, ar_sel=10. Go to EXE if STA, else RD.
- RD: operand read cycle, no strobes. Go to EXE.
- EXE: done=1, then act by opcode:
  - ADD/SUB/XOR/SHL/CMA: alu_en=1, ac_ld=1, ac_src=0.
  - LDA: ac_ld=1, ac_src=1.
  - STA: mem_write=1.
  - HLT: no strobe.
  - Next state is HALT for HLT. Otherwise F0 if start=1, else IDLE.
- HALT: halted=1. start=1 goes to F0; PC is not cleared.
- SC:
  - 0 in IDLE/HALT and in F0.
  - Increments by 1 each state transition within an instruction.
  - Maximum value 7 (EXE of an indirect load-type instruction); never wraps.
- alu_op = opcode at all times. ALU arithmetic is 8-bit modulo 2^8; carry is discarded.

## Timing
- Cycles per instruction:
  - Register-reference: 5.
  - Direct STA: 5.
  - Direct load-type: 6.
  - Indirect STA: 7.
  - Indirect load-type: 8.
- Back-to-back: if start is held high, EXE goes directly to F0 with no bubble.
- Reset value of all outputs is 0, including SC, opcode and I. The internal IR also clears to 0.
- RST mid-instruction:
  - Asynchronous return to IDLE; strobes drop immediately.
  - A partially executed instruction has no AC or memory side effect, because side effects occur only at the EXE edge.
- start is ignored outside IDLE, EXE and HALT.
- PC wraps F→0 with no special handling.
- Exactly one of {ac_ld, mem_write} is asserted per instruction, or neither for HLT.

## Test plan
- Reset: assert RST mid-F1.
  - All outputs must read 0 at once and state must be IDLE.
  - Releasing RST with start=0 must hold IDLE.
- Direct LDA: M[0]=0x49, M[9]=0x3C, start pulse.
  - Must see SC 0..5, ar_sel 00 then 01, ir_ld in cycle 2.
  - In cycle 5: ac_ld=1, ac_src=1. AC must become 0x3C. done pulses once.
- Indirect ADD: M[1]=0x86, M[6]=0x0A, M[10]=0x05, AC=0x3C.
  - Must take 8 cycles with ar_sel sequence 00, 01, 10.
  - AC must become 0x41. I must read 1.
- Direct STA then CMA: M[2]=0x5C, M[3]=0x60, AC=0x41.
  - STA: mem_write in SC=4 only; M[12] must become 0x41.
  - CMA: 5 cycles; AC must become 0xBE.
- HLT and restart: M[4]=0x70.
  - After 5 cycles halted=1 and busy=0.
  - A start pulse must fetch from address 5 (PC not cleared).
- Wrap: PC=0xF holding 0x60.
  - After the fetch PC must read 0x0.
  - With start held high, the next F0 must follow EXE immediately.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: sequencing FSM for the 8-bit accumulator CPU datapath.
// Runs fetch (F0..F2), decode, indirect resolution, operand read and execute,
// and produces every datapath strobe plus the cycle counter SC and the
// latched decode fields.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   start             begin execution (sampled in IDLE, EXE, HALT)
//   dr_in[7:0]        memory data register, loaded into the internal IR in F2
//   ar_ld, ar_sel     AR load strobe and source (00 PC, 01 IR[3:0], 10 DR[3:0])
//   pc_inc, ir_ld     PC increment, datapath IR load
//   mem_write         M[AR] <= AC
//   alu_en, alu_op    ALU evaluate strobe and opcode
//   ac_ld, ac_src     AC load and source (0 ALU, 1 DR)
//   SC, opcode, I     cycle index and latched instruction fields
//   busy, done, halted status
module control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] dr_in,
  output logic       ar_ld,
  output logic [1:0] ar_sel,
  output logic       pc_inc,
  output logic       ir_ld,
  output logic       mem_write,
  output logic       alu_en,
  output logic [2:0] alu_op,
  output logic       ac_ld,
  output logic       ac_src,
  output logic [2:0] SC,
  output logic [2:0] opcode,
  output logic       I,
  output logic       busy,
  output logic       done,
  output logic       halted
);

  localparam int unsigned OP_W = 3;
  localparam int unsigned SC_W = 3;

  localparam logic [OP_W-1:0] OP_LDA = 3'b100;
  localparam logic [OP_W-1:0] OP_STA = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b011;
  localparam logic [OP_W-1:0] OP_CMA = 3'b110;
  localparam logic [OP_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_IND0, S_IND1, S_RD, S_EXE, S_HALT
  } state_t;

  typedef struct packed {
    logic       ar_ld;
    logic [1:0] ar_sel;
    logic       pc_inc;
    logic       ir_ld;
    logic       mem_write;
    logic       alu_en;
    logic       ac_ld;
    logic       ac_src;
    logic       busy;
    logic       done;
    logic       halted;
  } ctrl_t;

  state_t      state, state_n;
  logic [7:0]  ir, ir_n;
  ctrl_t       ctrl, ctrl_n;
  logic [SC_W-1:0] sc_n;

  function automatic logic is_reg_op(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_CMA) || (op == OP_HLT);
  endfunction

  // Moore strobe decode for a given state and IR value
  function automatic ctrl_t decode(input state_t s, input logic [7:0] ir_v);
    ctrl_t d;
    d = '0;
    case (s)
      S_F0:   begin d.busy = 1'b1; d.ar_ld = 1'b1; d.ar_sel = 2'b00; end
      S_F1:   begin d.busy = 1'b1; d.pc_inc = 1'b1; end
      S_F2:   begin d.busy = 1'b1; d.ir_ld = 1'b1; end
      S_DEC: begin
        d.busy = 1'b1;
        if (!is_reg_op(ir_v[6:4])) begin
          d.ar_ld  = 1'b1;
          d.ar_sel = 2'b01;
        end
      end
      S_IND0: d.busy = 1'b1;
      S_IND1: begin d.busy = 1'b1; d.ar_ld = 1'b1; d.ar_sel = 2'b10; end
      S_RD:   d.busy = 1'b1;
      S_EXE: begin
        d.busy = 1'b1;
        d.done = 1'b1;
        case (ir_v[6:4])
          OP_LDA: begin d.ac_ld = 1'b1; d.ac_src = 1'b1; end
          OP_STA: d.mem_write = 1'b1;
          OP_HLT: ;
          default: begin d.alu_en = 1'b1; d.ac_ld = 1'b1; end
        endcase
      end
      S_HALT: d.halted = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  // State, IR latch and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      ir    <= '0;
      ctrl  <= '0;
      SC    <= '0;
    end else begin
      state <= state_n;
      ir    <= ir_n;
      ctrl  <= ctrl_n;
      SC    <= sc_n;
    end
  end

  // Next state and IR capture
  always_comb begin
    state_n = state;
    ir_n    = ir;
    case (state)
      S_IDLE: if (start) state_n = S_F0;
      S_F0:   state_n = S_F1;
      S_F1:   state_n = S_F2;
      S_F2: begin
        ir_n    = dr_in;
        state_n = S_DEC;
      end
      S_DEC: begin
        if (is_reg_op(ir[6:4]))   state_n = S_EXE;
        else if (ir[7])           state_n = S_IND0;
        else if (ir[6:4] == OP_STA) state_n = S_EXE;
        else                      state_n = S_RD;
      end
      S_IND0: state_n = S_IND1;
      S_IND1: state_n = (ir[6:4] == OP_STA) ? S_EXE : S_RD;
      S_RD:   state_n = S_EXE;
      S_EXE: begin
        if (ir[6:4] == OP_HLT) state_n = S_HALT;
        else if (start)        state_n = S_F0;
        else                   state_n = S_IDLE;
      end
      S_HALT: if (start) state_n = S_F0;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they stay Moore-aligned
  always_comb begin
    ctrl_n = decode(state_n, ir_n);
    sc_n   = SC_W'(SC + SC_W'(1));
    if (state_n == S_IDLE || state_n == S_HALT || state_n == S_F0) sc_n = '0;
  end

  assign ar_ld     = ctrl.ar_ld;
  assign ar_sel    = ctrl.ar_sel;
  assign pc_inc    = ctrl.pc_inc;
  assign ir_ld     = ctrl.ir_ld;
  assign mem_write = ctrl.mem_write;
  assign alu_en    = ctrl.alu_en;
  assign ac_ld     = ctrl.ac_ld;
  assign ac_src    = ctrl.ac_src;
  assign busy      = ctrl.busy;
  assign done      = ctrl.done;
  assign halted    = ctrl.halted;
  assign opcode    = ir[6:4];
  assign alu_op    = ir[6:4];
  assign I         = ir[7];

endmodule
